// File: rtl/dispatch_pkg.sv
// Shared instruction field map and hazard-key helpers for the dispatch FIFO.
// Key layout: src key = {flag bit 23, bits [10:0]}, dst key = {flag bit 22, bits [21:11]}.
package dispatch_pkg;

    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned KEY_W        = 12;

    // Instruction field positions
    localparam int unsigned PIN_BIT      = 27;
    localparam int unsigned CORE_SEL_BIT = 26;
    localparam int unsigned SRC_FLAG_BIT = 23;
    localparam int unsigned DST_FLAG_BIT = 22;
    localparam int unsigned DST_MSB      = 21;
    localparam int unsigned DST_LSB      = 11;
    localparam int unsigned SRC_MSB      = 10;
    localparam int unsigned SRC_LSB      = 0;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [KEY_W-1:0]   key_t;

    // Source-register hazard key of an instruction word
    function automatic key_t src_key(input instr_t d);
        return {d[SRC_FLAG_BIT], d[SRC_MSB:SRC_LSB]};
    endfunction

    // Destination-register hazard key of an instruction word
    function automatic key_t dst_key(input instr_t d);
        return {d[DST_FLAG_BIT], d[DST_MSB:DST_LSB]};
    endfunction

    // Instruction is pinned to its core
    function automatic logic is_pinned(input instr_t d);
        return d[PIN_BIT];
    endfunction

    // Core selected by the instruction
    function automatic logic core_sel(input instr_t d);
        return d[CORE_SEL_BIT];
    endfunction

endpackage

// File: rtl/dispatch_fifo_if.sv
// Arbiter/core-facing bus of the dispatch FIFO: push, pop, status and hazard query.
// master = arbiter/core side, slave = FIFO side.
interface dispatch_fifo_if #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
);
    import dispatch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             pop_ready;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             qry_en;
    key_t             qry_src;
    key_t             qry_dst;
    logic             hit_sd;
    logic             hit_ds;
    logic             hit_dd;

    modport master (
        output flush, push_valid, push_data, pop_ready, qry_en, qry_src, qry_dst,
        input  push_ready, pop_valid, pop_data, count, full, empty, hit_sd, hit_ds, hit_dd
    );

    modport slave (
        input  flush, push_valid, push_data, pop_ready, qry_en, qry_src, qry_dst,
        output push_ready, pop_valid, pop_data, count, full, empty, hit_sd, hit_ds, hit_dd
    );

endinterface

// File: rtl/dispatch_fifo_cam.sv
// Hazard CAM: compares the query keys against every valid FIFO entry.
// Results are combinational and forced low when the query is off or the FIFO is empty.
module dispatch_fifo_cam
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] i_entries,
    input  logic [DEPTH-1:0]            i_valid,
    input  logic                        i_qry_en,
    input  key_t                        i_qry_src,
    input  key_t                        i_qry_dst,
    input  logic                        i_empty,
    output logic                        o_hit_sd,
    output logic                        o_hit_ds,
    output logic                        o_hit_dd
);

    logic [DEPTH-1:0] w_match_sd;
    logic [DEPTH-1:0] w_match_ds;
    logic [DEPTH-1:0] w_match_dd;

    // Only the key fields take part in matching; fold the rest so it is visibly consumed
    logic w_unused_bits;
    assign w_unused_bits = ^i_entries;

    // Per-entry key comparison, qualified by the entry valid bit
    always_comb begin
        w_match_sd = '0;
        w_match_ds = '0;
        w_match_dd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match_sd[i] = i_valid[i] && (i_qry_src == dst_key(i_entries[i]));
            w_match_ds[i] = i_valid[i] && (i_qry_dst == src_key(i_entries[i]));
            w_match_dd[i] = i_valid[i] && (i_qry_dst == dst_key(i_entries[i]));
        end
    end

    // Reduce per-entry matches into the three hit flags
    always_comb begin
        if (i_qry_en && !i_empty) begin
            o_hit_sd = |w_match_sd;
            o_hit_ds = |w_match_ds;
            o_hit_dd = |w_match_dd;
        end else begin
            o_hit_sd = 1'b0;
            o_hit_ds = 1'b0;
            o_hit_dd = 1'b0;
        end
    end

endmodule

// File: rtl/dispatch_fifo.sv
// Instruction dispatch FIFO between the arbiter and a core, with a hazard-query CAM.
// Optional feature: define DISPATCH_FIFO_BYPASS_EN to let a push pass straight to the
// pop side while the FIFO is empty (bypassed words never enter storage or the CAM).
module dispatch_fifo
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            resetn,
    dispatch_fifo_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [DEPTH-1:0] ONE_HOT0  = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [DEPTH-1:0]            r_valid;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_count;
    logic                        r_full;
    logic                        r_empty;

    logic                        w_bypass_take;
    logic                        w_push_acc;
    logic                        w_pop_acc;
    logic [CNT_W-1:0]            w_count_nxt;
    logic [DEPTH-1:0]            w_set_mask;
    logic [DEPTH-1:0]            w_clr_mask;
    logic [DEPTH-1:0]            w_valid_nxt;

    // Decode which handshakes complete on the coming edge
    always_comb begin
`ifdef DISPATCH_FIFO_BYPASS_EN
        w_bypass_take = r_empty && bus.push_valid && bus.pop_ready;
`else
        w_bypass_take = 1'b0;
`endif
        w_push_acc = bus.push_valid && !r_full && !w_bypass_take;
        w_pop_acc  = !r_empty && bus.pop_ready;
    end

    // Next occupancy and entry-valid vector from the accepted push/pop
    always_comb begin
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
        w_set_mask  = w_push_acc ? (ONE_HOT0 << r_wr_ptr) : '0;
        w_clr_mask  = w_pop_acc  ? (ONE_HOT0 << r_rd_ptr) : '0;
        w_valid_nxt = (r_valid & ~w_clr_mask) | w_set_mask;
    end

    // Pointers, occupancy flags and valid bits; reset outranks flush, flush outranks traffic
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_valid  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_valid  <= '0;
        end else begin
            r_wr_ptr <= w_push_acc ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
            r_rd_ptr <= w_pop_acc  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CNT_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_valid  <= w_valid_nxt;
        end
    end

    // Payload storage; validity is tracked separately so this RAM needs no reset
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.push_data;
        end
    end

    // Pop side: head entry, or the offered push while empty when bypass is built in
    always_comb begin
`ifdef DISPATCH_FIFO_BYPASS_EN
        if (r_empty) begin
            bus.pop_valid = bus.push_valid;
            bus.pop_data  = bus.push_data;
        end else begin
            bus.pop_valid = 1'b1;
            bus.pop_data  = r_mem[r_rd_ptr];
        end
`else
        bus.pop_valid = !r_empty;
        bus.pop_data  = r_mem[r_rd_ptr];
`endif
    end

    assign bus.push_ready = !r_full;
    assign bus.count      = r_count;
    assign bus.full       = r_full;
    assign bus.empty      = r_empty;

    dispatch_fifo_cam #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_cam (
        .i_entries (r_mem),
        .i_valid   (r_valid),
        .i_qry_en  (bus.qry_en),
        .i_qry_src (bus.qry_src),
        .i_qry_dst (bus.qry_dst),
        .i_empty   (r_empty),
        .o_hit_sd  (bus.hit_sd),
        .o_hit_ds  (bus.hit_ds),
        .o_hit_dd  (bus.hit_dd)
    );

endmodule

// File: tb/tb_dispatch_fifo.sv
// Bench for dispatch_fifo: queue-based reference model checked every cycle on the
// falling edge, plus directed literal expectations. Honors DISPATCH_FIFO_BYPASS_EN.
`timescale 1ns/1ps
module tb_dispatch_fifo;
    import dispatch_pkg::*;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
`ifdef DISPATCH_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dispatch_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    dispatch_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [31:0] mq[$];
    bit          chk_en = 1'b0;
    int          n_vec  = 0;
    int          n_err  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] m_skey(input logic [31:0] d);
        return {d[23], d[10:0]};
    endfunction

    function automatic logic [11:0] m_dkey(input logic [31:0] d);
        return {d[22], d[21:11]};
    endfunction

    function automatic bit any_dst(input logic [11:0] k);
        foreach (mq[i]) if (m_dkey(mq[i]) == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_src(input logic [11:0] k);
        foreach (mq[i]) if (m_skey(mq[i]) == k) return 1'b1;
        return 1'b0;
    endfunction

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        int sz;
        bit en;
        bit exp_pv;
        if (chk_en) begin
            sz = mq.size();
            en = bus.qry_en && (sz > 0);
            exp_pv = (sz > 0) || (BYP && bus.push_valid);
            chk("count",      32'(bus.count),      32'(sz));
            chk("full",       32'(bus.full),       32'(sz == DEPTH));
            chk("empty",      32'(bus.empty),      32'(sz == 0));
            chk("push_ready", 32'(bus.push_ready), 32'(sz != DEPTH));
            chk("pop_valid",  32'(bus.pop_valid),  32'(exp_pv));
            if (exp_pv) chk("pop_data", bus.pop_data, (sz > 0) ? mq[0] : bus.push_data);
            chk("hit_sd", 32'(bus.hit_sd), 32'(en && any_dst(bus.qry_src)));
            chk("hit_ds", 32'(bus.hit_ds), 32'(en && any_src(bus.qry_dst)));
            chk("hit_dd", 32'(bus.hit_dd), 32'(en && any_dst(bus.qry_dst)));
        end
    end

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        int sz;
        bit pop;
        bit push;
        @(posedge clk);
        sz = mq.size();
        if (!resetn || bus.flush) begin
            mq.delete();
        end else if (BYP && sz == 0 && bus.push_valid && bus.pop_ready) begin
            sz = 0;
        end else begin
            pop  = (sz > 0) && bus.pop_ready;
            push = bus.push_valid && (sz < DEPTH);
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(bus.push_data);
        end
        #1;
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_data  = 32'h0;
        bus.pop_ready  = 1'b0;
        bus.qry_en     = 1'b0;
        bus.qry_src    = 12'h0;
        bus.qry_dst    = 12'h0;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full),  32'd0);
        resetn = 1'b1;

        // Two pushes with the core stalled
        bus.push_valid = 1'b1; bus.push_data = 32'h0000_0801;
        #1;
        chk("pv_same_cycle", 32'(bus.pop_valid), BYP ? 32'd1 : 32'd0);
        tick();
        bus.push_data = 32'h0040_1002;
        #1;
        chk("pv_after_1", 32'(bus.pop_valid), 32'd1);
        chk("head_first", bus.pop_data, 32'h0000_0801);
        tick();
        bus.push_valid = 1'b0;
        chk("count_2", 32'(bus.count), 32'd2);
        chk("head_keep", bus.pop_data, 32'h0000_0801);
        bus.qry_en = 1'b1; bus.qry_src = 12'h802; bus.qry_dst = 12'h002;
        #1;
        chk("q_sd", 32'(bus.hit_sd), 32'd1);
        chk("q_ds", 32'(bus.hit_ds), 32'd1);
        chk("q_dd", 32'(bus.hit_dd), 32'd0);
        bus.qry_en = 1'b0;
        bus.pop_ready = 1'b1;
        tick();
        tick();
        bus.pop_ready = 1'b0;
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // dst-key hit disappears once the entry is popped
        bus.push_valid = 1'b1; bus.push_data = 32'h0000_2800;
        tick();
        bus.push_valid = 1'b0;
        bus.qry_en = 1'b1; bus.qry_src = 12'h000; bus.qry_dst = 12'h005;
        #1;
        chk("dd_held", 32'(bus.hit_dd), 32'd1);
        bus.pop_ready = 1'b1;
        tick();
        bus.pop_ready = 1'b0;
        chk("dd_popped", 32'(bus.hit_dd), 32'd0);
        bus.qry_en = 1'b0;

        // Fill to DEPTH, then offer one more with a pop in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            bus.push_valid = 1'b1; bus.push_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        bus.push_valid = 1'b1; bus.push_data = 32'hDEAD_0033; bus.pop_ready = 1'b1;
        #1;
        chk("full_at_33", 32'(bus.full), 32'd1);
        chk("ready_at_33", 32'(bus.push_ready), 32'd0);
        tick();
        bus.push_valid = 1'b0; bus.pop_ready = 1'b0;
        chk("count_31", 32'(bus.count), 32'd31);
        for (int i = 1; i < DEPTH; i++) begin
            bus.pop_ready = 1'b1;
            #1;
            chk("drain_order", bus.pop_data, 32'h1000_0000 + 32'(i));
            tick();
        end
        bus.pop_ready = 1'b0;
        chk("no_33rd", 32'(bus.empty), 32'd1);

        // 40 interleaved pushes and pops, wrapping the pointers
        for (int i = 0; i < 40; i++) begin
            bus.push_valid = 1'b1; bus.push_data = 32'h2000_0000 + 32'(i);
            bus.pop_ready = (i > 0);
            tick();
        end
        chk("steady_count", 32'(bus.count), 32'd1);
        bus.push_valid = 1'b0; bus.pop_ready = 1'b1;
        #1;
        chk("last_out", bus.pop_data, 32'h2000_0027);
        tick();
        bus.pop_ready = 1'b0;
        chk("inter_empty", 32'(bus.empty), 32'd1);

        // Bursty mixed traffic with live queries
        for (int i = 0; i < 60; i++) begin
            bus.push_valid = (i % 3) != 0;
            bus.push_data  = 32'h4000_0000 | (32'(i) << 11) | 32'(i);
            bus.pop_ready  = (i % 4) < 2;
            bus.qry_en     = 1'b1;
            bus.qry_src    = 12'(i - 2);
            bus.qry_dst    = 12'(i - 1);
            tick();
        end
        idle();

        // Flush with 5 entries held and a push offered
        for (int i = 0; i < 5; i++) begin
            bus.push_valid = 1'b1; bus.push_data = 32'h3000_0000 + 32'(i);
            tick();
        end
        bus.qry_en = 1'b1; bus.qry_dst = 12'h000; bus.qry_src = 12'h000;
        #1;
        chk("dd_preflush", 32'(bus.hit_dd), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.push_valid = 1'b0;
        chk("fl_count", 32'(bus.count), 32'd0);
        chk("fl_empty", 32'(bus.empty), 32'd1);
        chk("fl_hits", 32'({bus.hit_sd, bus.hit_ds, bus.hit_dd}), 32'd0);
        bus.qry_en = 1'b0;

        // Reset in the middle of traffic
        for (int i = 0; i < 4; i++) begin
            bus.push_valid = 1'b1; bus.push_data = 32'h5000_0000 + 32'(i);
            bus.pop_ready = (i == 2);
            tick();
        end
        resetn = 1'b0;
        tick();
        idle();
        #1;
        chk("mr_count", 32'(bus.count), 32'd0);
        chk("mr_empty", 32'(bus.empty), 32'd1);
        chk("mr_full", 32'(bus.full), 32'd0);
        chk("mr_ready", 32'(bus.push_ready), 32'd1);
        chk("mr_pvalid", 32'(bus.pop_valid), 32'd0);
        resetn = 1'b1;
        tick();

        // Push into an empty FIFO with the core ready
        bus.push_valid = 1'b1; bus.push_data = 32'h0000_0123; bus.pop_ready = 1'b1;
        #1;
        chk("byp_pvalid", 32'(bus.pop_valid), BYP ? 32'd1 : 32'd0);
        tick();
        bus.push_valid = 1'b0; bus.pop_ready = 1'b0;
        chk("byp_count", 32'(bus.count), BYP ? 32'd0 : 32'd1);
        chk("byp_head", 32'(bus.pop_valid) & 32'(!BYP) ? bus.pop_data : 32'h0000_0123,
            32'h0000_0123);
        bus.pop_ready = 1'b1;
        tick();
        bus.pop_ready = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dispatch_fifo.md
DISPATCH_FIFO -- requirements
Module: dispatch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of instruction entries; power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default 32, instruction word width; fixed at 32 for the field map.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of all entries.
REQ-006 SHALL have port push_valid  input  1  arbiter offers an instruction.
REQ-007 SHALL have port push_data  input  WIDTH  instruction from the arbiter.
REQ-008 SHALL have port push_ready  output  1  equals !full.
REQ-009 SHALL have port pop_valid  output  1  head instruction available to the core.
REQ-010 SHALL have port pop_data  output  WIDTH  head instruction.
REQ-011 SHALL have port pop_ready  input  1  core accepts the head.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.
REQ-013 SHALL have ports full and empty  output  1 each  occupancy flags.
REQ-014 SHALL have ports qry_en  input  1, qry_src  input  12, qry_dst  input  12  hazard query from the arbiter.
REQ-015 SHALL have ports hit_sd, hit_ds, hit_dd  output  1 each  query match results.

Function
REQ-016 SHALL accept a push on a rising edge only when push_valid and push_ready are both 1.
REQ-017 SHALL pop on a rising edge only when pop_valid and pop_ready are both 1, advancing the head by one.
REQ-018 SHALL keep push_ready low while full, even if a pop occurs in the same cycle; an offered push is not stored.
REQ-019 SHALL, on simultaneous accepted push and pop, leave count unchanged.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; an entry is invalid after it is popped.
REQ-021 SHALL drive pop_data as the head entry; pop_data is don't-care while pop_valid is 0.
REQ-022 SHALL define per-entry keys: src key {d[23], d[10:0]} and dst key {d[22], d[21:11]}.
REQ-023 SHALL set, combinationally over valid entries only: hit_sd when qry_src equals any dst key; hit_ds when qry_dst equals any src key; hit_dd when qry_dst equals any dst key.
REQ-024 SHALL force all hit outputs to 0 when qry_en is 0 or the FIFO is empty.
REQ-025 SHALL give flush priority over push and pop: next state is empty and count 0, with any same-cycle push discarded.
REQ-026 SHALL update full, empty and count registered, coherent with the pointers on every edge.

Reset
REQ-027 SHALL, when resetn is 0 at a rising edge, set pointers and count to 0, empty=1, full=0, push_ready=1, pop_valid=0, and invalidate all entries.
REQ-028 SHALL give reset priority over flush, push and pop; the payload RAM need not be cleared.

Configuration
REQ-029 SHALL support macro DISPATCH_FIFO_BYPASS_EN: when defined and the FIFO is empty, push_valid drives pop_valid and push_data drives pop_data combinationally; a same-cycle pop_ready consumes it without storage and count stays 0.
REQ-030 SHALL, with DISPATCH_FIFO_BYPASS_EN undefined, give push-to-pop_valid latency of exactly 1 cycle, and pop_valid SHALL equal !empty.
REQ-031 SHALL exclude bypassed instructions from query matching in both configurations.

Structure
REQ-032 SHALL place instruction field positions (bit 27 pin, bit 26 core select, bits 23/22 key flags, [21:11] dst, [10:0] src), the 12-bit key typedef, and the key-extract functions in shared package dispatch_pkg.
REQ-033 SHALL implement the matching in sub-module dispatch_fifo_cam, which takes the entry array plus a valid vector and returns the three hits.

Verification
REQ-034 Push 0x0000_0801 and 0x0040_1002 with pop_ready=0 -> count=2; pop_data=0x0000_0801; in non-bypass mode pop_valid rises 1 cycle after the first push.
REQ-035 Push 32 entries, offer a 33rd with pop_ready=1 -> 33rd not stored; full=1 for that cycle; count=31 after the edge; the 33rd is absent from the output sequence.
REQ-036 After 40 pushes and 40 pops in interleaved mode -> output order matches input order, the pointers wrap, and empty=1 at the end.
REQ-037 Hold an entry with dst key 0x005; query with qry_dst=0x005 and qry_en=1 -> hit_dd=1. Pop that entry, repeat the query -> hit_dd=0.
REQ-038 Assert flush with push_valid=1 and 5 entries held -> next cycle count=0, empty=1, all hits 0. Assert resetn=0 mid-stream -> all REQ-027 values hold.
REQ-039 With DISPATCH_FIFO_BYPASS_EN defined, FIFO empty, push 0x0000_0123 with pop_ready=1 -> pop_data=0x0000_0123 in the same cycle and count remains 0.
